// File: rtl/eth_tx_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream TX datapath between
// the RDMA data path (port 0) and the ACK/control path (port 1).
module eth_tx_stream_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic                    s0_axis_tvalid,
  output logic                    s0_axis_tready,
  input  logic                    s0_axis_tlast,
  input  logic [DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic                    s1_axis_tvalid,
  output logic                    s1_axis_tready,
  input  logic                    s1_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [1:0]              grant,
  output logic [CNT_WIDTH-1:0]    frame_cnt0,
  output logic [CNT_WIDTH-1:0]    frame_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   out_free;
  logic   acc0;
  logic   acc1;

  // The single output register can take a new beat when empty or draining.
  assign out_free       = !m_axis_tvalid || m_axis_tready;
  assign s0_axis_tready = (state == GNT0) && out_free;
  assign s1_axis_tready = (state == GNT1) && out_free;
  assign acc0           = s0_axis_tvalid && s0_axis_tready;
  assign acc1           = s1_axis_tvalid && s1_axis_tready;

  // Arbitration FSM: grant held from first beat until the tlast beat is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant)) begin
            state <= GNT0;
            grant <= 2'b01;
          end else if (s1_axis_tvalid) begin
            state <= GNT1;
            grant <= 2'b10;
          end
        end
        GNT0: begin
          if (acc0 && s0_axis_tlast) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b0;
          end
        end
        GNT1: begin
          if (acc1 && s1_axis_tlast) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (acc0) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s0_axis_tdata;
      m_axis_tkeep  <= s0_axis_tkeep;
      m_axis_tlast  <= s0_axis_tlast;
    end else if (acc1) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s1_axis_tdata;
      m_axis_tkeep  <= s1_axis_tkeep;
      m_axis_tlast  <= s1_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Per-port frame counters, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
    end else begin
      if (acc0 && s0_axis_tlast) frame_cnt0 <= frame_cnt0 + CNT_WIDTH'(1);
      if (acc1 && s1_axis_tlast) frame_cnt1 <= frame_cnt1 + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_eth_tx_stream_arbiter.sv
// Scoreboard bench for eth_tx_stream_arbiter: per-port frame queues model the
// expected output; a negedge monitor checks ordering, latency, stalls and grants.
module tb_eth_tx_stream_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = 8;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [1:0]    grant;
  logic [CW-1:0] frame_cnt0, frame_cnt1;

  beat_t tx_q0[$], tx_q1[$], exp_q0[$], exp_q1[$];
  int    frame_order[$];
  int    checks = 0;
  int    errors = 0;
  int    cnt_model0 = 0, cnt_model1 = 0;
  int    acc_cnt0 = 0, acc_cnt1 = 0;
  int    gap_pct = 0, stall_pct = 0, hold_n = 0;
  logic  hs0 = 1'b0, hs1 = 1'b0;

  always #5 clk = ~clk;

  eth_tx_stream_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s0_axis_tlast(s0_axis_tlast),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .s1_axis_tlast(s1_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .grant(grant), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1)
  );

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Queue a frame for a port; the same beats become the expected output.
  task automatic send_frame(input int port, input int len, input logic [63:0] base, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? {$urandom, $urandom} : base + 64'(i);
      b.keep = rnd ? (($urandom_range(7) == 0) ? 8'h00 : 8'($urandom)) : 8'hFF;
      b.last = (i == len - 1);
      if (port == 0) begin tx_q0.push_back(b); exp_q0.push_back(b); end
      else           begin tx_q1.push_back(b); exp_q1.push_back(b); end
    end
  endtask

  // Source/sink driver: updates #1 after posedge, handshakes sampled at negedge.
  initial begin
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tlast = 1'b0;
    m_axis_tready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hs0) begin
        acc_cnt0++;
        if (tx_q0.size() > 0) begin
          if (tx_q0[0].last) cnt_model0++;
          void'(tx_q0.pop_front());
        end
      end
      if (hs1) begin
        acc_cnt1++;
        if (tx_q1.size() > 0) begin
          if (tx_q1[0].last) cnt_model1++;
          void'(tx_q1.pop_front());
        end
      end
      s0_axis_tvalid = (tx_q0.size() > 0) && (int'($urandom_range(99)) >= gap_pct);
      s1_axis_tvalid = (tx_q1.size() > 0) && (int'($urandom_range(99)) >= gap_pct);
      if (tx_q0.size() > 0) {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast} = tx_q0[0];
      if (tx_q1.size() > 0) {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast} = tx_q1[0];
      if (hold_n > 0) begin
        m_axis_tready = 1'b0;
        hold_n--;
      end else begin
        m_axis_tready = int'($urandom_range(99)) >= stall_pct;
      end
      @(negedge clk);
      hs0 = s0_axis_tvalid && s0_axis_tready && !rst;
      hs1 = s1_axis_tvalid && s1_axis_tready && !rst;
    end
  end

  // Monitor / scoreboard.
  beat_t prev_acc, prev_m, ob, a0b, a1b, expb;
  bit    prev_acc_v = 1'b0, prev_stall = 1'b0, a0, a1;
  int    cur_port = -1;

  always @(negedge clk) begin
    if (rst) begin
      prev_acc_v = 1'b0;
      prev_stall = 1'b0;
      cur_port   = -1;
    end else begin
      ob  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      a0b = {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast};
      a1b = {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast};
      chk(grant != 2'b11, "grant_onehot", 64'(grant), 64'(0));
      if (prev_acc_v) begin
        chk(m_axis_tvalid && (ob == prev_acc), "latency1", ob.data, prev_acc.data);
        if (prev_acc.last) chk(grant == 2'b00, "frame_gap_idle", 64'(grant), 64'(0));
      end
      if (prev_stall)
        chk(m_axis_tvalid && (ob == prev_m), "stall_hold", ob.data, prev_m.data);
      if (m_axis_tvalid && !m_axis_tready)
        chk(!s0_axis_tready && !s1_axis_tready, "ready_when_full",
            64'({s1_axis_tready, s0_axis_tready}), 64'(0));
      a0 = s0_axis_tvalid && s0_axis_tready;
      a1 = s1_axis_tvalid && s1_axis_tready;
      if (a0 || a1) begin
        chk(!(a0 && a1), "single_accept", 64'({a1, a0}), 64'(1));
        chk(grant == (a0 ? 2'b01 : 2'b10), "grant_owner", 64'(grant), a0 ? 64'(1) : 64'(2));
      end
      prev_acc_v = a0 || a1;
      prev_acc   = a0 ? a0b : a1b;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_m     = ob;
      if (m_axis_tvalid && m_axis_tready) begin
        if (cur_port < 0) begin
          if (exp_q0.size() > 0 && exp_q0[0] == ob) cur_port = 0;
          else if (exp_q1.size() > 0 && exp_q1[0] == ob) cur_port = 1;
          checks++;
          if (cur_port < 0) begin
            errors++;
            $display("FAIL out_frame_start: got 0x%0h, required the head beat of a queued frame", ob.data);
          end else begin
            frame_order.push_back(cur_port);
            if (cur_port == 0) void'(exp_q0.pop_front());
            else               void'(exp_q1.pop_front());
          end
        end else if (cur_port == 0) begin
          expb = (exp_q0.size() > 0) ? exp_q0[0] : '0;
          chk(exp_q0.size() > 0 && ob == expb, "out_beat_p0", ob.data, expb.data);
          if (exp_q0.size() > 0) void'(exp_q0.pop_front());
        end else begin
          expb = (exp_q1.size() > 0) ? exp_q1[0] : '0;
          chk(exp_q1.size() > 0 && ob == expb, "out_beat_p1", ob.data, expb.data);
          if (exp_q1.size() > 0) void'(exp_q1.pop_front());
        end
        if (ob.last) cur_port = -1;
      end
    end
  end

  // Apply reset (caller aligns away from edges) and check asynchronous clearing.
  task automatic do_reset();
    rst = 1'b1;
    tx_q0.delete(); tx_q1.delete(); exp_q0.delete(); exp_q1.delete();
    cnt_model0 = 0; cnt_model1 = 0; hold_n = 0;
    #1;
    chk(!m_axis_tvalid, "rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk(grant == 2'b00, "rst_grant", 64'(grant), 64'(0));
    chk(frame_cnt0 == 0 && frame_cnt1 == 0, "rst_counters", 64'({frame_cnt1, frame_cnt0}), 64'(0));
    chk(!s0_axis_tready && !s1_axis_tready, "rst_tready", 64'({s1_axis_tready, s0_axis_tready}), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((tx_q0.size() > 0 || tx_q1.size() > 0 || exp_q0.size() > 0 ||
            exp_q1.size() > 0 || m_axis_tvalid) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats still queued, required 0", name,
               tx_q0.size() + tx_q1.size() + exp_q0.size() + exp_q1.size());
      tx_q0.delete(); tx_q1.delete(); exp_q0.delete(); exp_q1.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_counters(input string name);
    chk(frame_cnt0 == CW'(cnt_model0), {name, "_cnt0"}, 64'(frame_cnt0), 64'(cnt_model0 % 16));
    chk(frame_cnt1 == CW'(cnt_model1), {name, "_cnt1"}, 64'(frame_cnt1), 64'(cnt_model1 % 16));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time %0t, required completion earlier", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] v;
    int st, n;
    beat_t b;
    rst = 1'b0;
    #2;
    do_reset();

    // Single requester, 7-beat frame on port 0.
    for (int i = 0; i < 7; i++) begin
      v = (i == 0) ? 64'h000A35000102000A : (i == 6) ? 64'hAABBCCDDEEFF0011 : 64'h0800450000000000 + 64'(i);
      b = {v, 8'hFF, 1'b0};
      b.last = (i == 6);
      tx_q0.push_back(b);
      exp_q0.push_back(b);
    end
    wait_drain("single");
    chk(frame_cnt0 == 4'd1 && frame_cnt1 == 4'd0, "single_counts", 64'({frame_cnt1, frame_cnt0}), 64'h01);

    // Simultaneous requests right after reset: port 0 first.
    @(posedge clk); #3; do_reset();
    frame_order.delete();
    send_frame(0, 3, 64'h0000_00AA_0000_0000, 1'b0);
    send_frame(1, 3, 64'h1111_00BB_0000_0000, 1'b0);
    wait_drain("simul");
    chk(frame_order.size() == 2, "simul_nframes", 64'(frame_order.size()), 64'(2));
    if (frame_order.size() == 2)
      chk(frame_order[0] == 0 && frame_order[1] == 1, "simul_order",
          64'({frame_order[0][3:0], frame_order[1][3:0]}), 64'h01);

    // Fairness: continuous 2-beat frames on both ports alternate.
    @(posedge clk); #3; do_reset();
    frame_order.delete();
    for (int i = 0; i < 4; i++) begin
      send_frame(0, 2, 64'h0000_0F00_0000_0000 + 64'(i << 8), 1'b0);
      send_frame(1, 2, 64'h1111_0F00_0000_0000 + 64'(i << 8), 1'b0);
    end
    wait_drain("fair");
    chk(frame_order.size() == 8, "fair_nframes", 64'(frame_order.size()), 64'(8));
    for (int i = 0; i < frame_order.size(); i++)
      chk(frame_order[i] == (i % 2), "fair_alternate", 64'(frame_order[i]), 64'(i % 2));
    chk(frame_cnt0 == 4'd4 && frame_cnt1 == 4'd4, "fair_counts", 64'({frame_cnt1, frame_cnt0}), 64'h44);

    // Backpressure during a port 1 frame.
    st = acc_cnt1;
    send_frame(1, 5, 64'h1111_BEEF_0000_0000, 1'b0);
    n = 0;
    while (acc_cnt1 < st + 2 && n < 200) begin @(posedge clk); #2; n++; end
    hold_n = 3;
    wait_drain("bp");
    chk_counters("bp");

    // Counter wrap: 17 frames on port 1 with 4-bit counters.
    @(posedge clk); #3; do_reset();
    for (int i = 0; i < 17; i++) send_frame(1, 1 + int'($urandom_range(2)), 64'h0, 1'b1);
    wait_drain("wrap");
    chk(frame_cnt1 == 4'd1, "wrap_cnt1", 64'(frame_cnt1), 64'(1));
    chk_counters("wrap");

    // Reset after beat 3 of a 6-beat port 0 frame, then a normal port 1 frame.
    st = acc_cnt0;
    send_frame(0, 6, 64'h0000_DEAD_0000_0000, 1'b0);
    n = 0;
    while (acc_cnt0 < st + 3 && n < 200) begin @(posedge clk); #2; n++; end
    chk(n < 200, "midrst_reach_beat3", 64'(acc_cnt0 - st), 64'(3));
    #1; do_reset();
    frame_order.delete();
    send_frame(1, 4, 64'h1111_CAFE_0000_0000, 1'b0);
    wait_drain("midrst");
    chk(frame_order.size() == 1 && frame_order[0] == 1, "midrst_next_p1",
        64'(frame_order.size()), 64'(1));
    chk(frame_cnt1 == 4'd1 && frame_cnt0 == 4'd0, "midrst_counts", 64'({frame_cnt1, frame_cnt0}), 64'h10);

    // Randomized traffic with gaps, withdrawals and downstream stalls.
    gap_pct = 30; stall_pct = 30;
    for (int i = 0; i < 40; i++)
      send_frame(int'($urandom_range(1)), 1 + int'($urandom_range(5)), 64'h0, 1'b1);
    wait_drain("random");
    chk_counters("random");
    gap_pct = 0; stall_pct = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_stream_arbiter.md
Name: eth_tx_stream_arbiter

Overview:
Packet-level round-robin arbiter that shares the 64-bit AXI-Stream Ethernet TX datapath between two requesters. Port 0 is the RDMA data/encapsulator path and port 1 is the ACK/control path. A grant is held from the first beat of a frame until its tlast beat is accepted, so frames never interleave. A single registered output stage drives the MAC/TX stream.

Parameters:
DATA_WIDTH, 64, AXI-Stream data width in bits; tkeep width is DATA_WIDTH/8.
CNT_WIDTH, 16, width of the per-port frame counters.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
s0_axis_tdata  in  DATA_WIDTH  port 0 data
s0_axis_tkeep  in  DATA_WIDTH/8  port 0 byte enables
s0_axis_tvalid  in  1  port 0 valid
s0_axis_tready  out  1  port 0 ready
s0_axis_tlast  in  1  port 0 end of frame
s1_axis_tdata/tkeep/tvalid/tready/tlast  same as port 0, for port 1
m_axis_tdata  out  DATA_WIDTH  output data
m_axis_tkeep  out  DATA_WIDTH/8  output byte enables
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  output end of frame
grant  out  2  one-hot current owner; 00 when idle
frame_cnt0  out  CNT_WIDTH  count of frames accepted from port 0
frame_cnt1  out  CNT_WIDTH  count of frames accepted from port 1

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE. grant=00, last_grant=1. m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0. Both frame counters=0. Both s*_tready=0.
- FSM states:
  - IDLE: no grant.
    - If only s0_tvalid is high, go to GNT0. If only s1_tvalid is high, go to GNT1.
    - If both are high, grant the port not equal to last_grant.
    - Grant is registered and takes effect the next cycle.
    - While in IDLE, both s*_tready are 0.
  - GNT0 / GNT1: granted port ready = (!m_axis_tvalid || m_axis_tready). The non-granted port's ready is 0.
    - On acceptance of a beat with tlast=1, last_grant takes the current port and the FSM returns to IDLE.
- Frame gap: there is exactly one IDLE cycle between consecutive frames at the input side.
- Beat validity: tvalid on a granted port with tkeep=0 is still forwarded unchanged. There is no tkeep checking.
- Output stage:
  - On an input accept, m_axis_* loads the input beat and m_axis_tvalid=1.
  - Else if m_axis_tready=1, m_axis_tvalid is cleared.
  - Data holds stable while tvalid=1 and tready=0.
  - Input-to-output latency is 1 cycle. Sustained throughput is 1 beat/cycle within a frame.
- Counters: frame_cntN increments on input acceptance of a tlast beat from port N. They wrap modulo 2^CNT_WIDTH with no saturation.
- Requester withdraws: a requester dropping tvalid mid-frame keeps the grant. The arbiter waits indefinitely for that port's tlast.
- Reset mid-frame: the output is truncated (no tlast emitted) and the FSM returns to IDLE. The upstream sources are responsible for restarting their frames.
- Grant timing: the port granted in IDLE is determined solely by that cycle's tvalids. A tvalid arriving one cycle later waits for the next arbitration.

Test Plan:
- Single requester: port 0 sends a 7-beat frame (0x000A35000102000A ... payload 0xAABBCCDDEEFF0011, tlast on beat 7) with m_axis_tready=1.
  Required: grant=01 from cycle 1; output beats appear 1 cycle after each acceptance, in order, tlast on beat 7; frame_cnt0=1, frame_cnt1=0.
- Simultaneous requests: both ports hold a 3-beat frame valid after reset.
  Required: port 0 is sent first (last_grant=1 at reset), then one IDLE cycle, then port 1; output order is P0 b0-b2 then P1 b0-b2; no interleave.
- Fairness: both ports continuously offer 2-beat frames for 8 frames total.
  Required: grants alternate 01,10,01,...; frame_cnt0=4, frame_cnt1=4.
- Backpressure: during a port 1 frame, deassert m_axis_tready for 3 cycles.
  Required: m_axis_tdata, tkeep and tlast stay stable with tvalid=1; s1_axis_tready=0 while the output is full and stalled; no beat lost or duplicated.
- Counter wrap: with CNT_WIDTH=4, send 17 frames on port 1.
  Required: frame_cnt1=1.
- Reset mid-frame: assert rst after beat 3 of a 6-beat port 0 frame.
  Required: m_axis_tvalid=0 and grant=00 immediately (asynchronous); counters=0; the next frame offered on port 1 is granted normally.
